// File: rtl/cache_nway_ctrl.sv
// cache_nway_ctrl: N-way set-associative, write-through, write-allocate cache
// with its own refill FSM, true-LRU replacement and saturating hit/miss counters.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req_*               CPU request (valid/we/addr/wdata), req_ready handshake
//   rsp_valid/rsp_rdata one-cycle response pulse, read data (0 when idle)
//   miss_detected       high while a miss is being serviced
//   mem_rd_*            block refill from main memory, one word per mem_rd_valid
//   mem_wr_*            write-through port, held until mem_wr_ack
//   stat_clr            synchronous clear of hit_count/miss_count
//   hit_count/miss_count saturating statistics

// One way of the cache: tag/valid/data storage for every set plus that way's
// LRU age per set. Instantiated once per way by the top.
module cache_nway_way #(
  parameter int DATA_WIDTH = 16,
  parameter int SETS       = 64,
  parameter int WORDS      = 8,
  parameter int TAG_W      = 6,
  parameter int IDX_W      = 6,
  parameter int WW         = 3,
  parameter int WAYS       = 2,
  parameter int AGE_W      = 1,
  parameter int WAY_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      idx,
  input  logic [WW-1:0]         word,
  input  logic [TAG_W-1:0]      cmp_tag,
  output logic                  hit,
  output logic                  vld,
  output logic [AGE_W-1:0]      age,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  wr_en,
  input  logic [WW-1:0]         wr_word,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  tag_wr,
  input  logic                  inv,
  input  logic                  lru_upd,
  input  logic [AGE_W-1:0]      lru_acc_age,
  input  logic                  lru_sel
);
  logic [SETS-1:0]       valid;
  logic [TAG_W-1:0]      tag_mem  [SETS];
  logic [DATA_WIDTH-1:0] data_mem [SETS*WORDS];

  assign vld   = valid[idx];
  assign hit   = valid[idx] && (tag_mem[idx] == cmp_tag);
  assign rdata = data_mem[{idx, word}];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        valid      <= '0;
    else if (tag_wr) valid[idx] <= 1'b1;
    else if (inv)    valid[idx] <= 1'b0;
  end

  // Storage arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (tag_wr) tag_mem[idx]              <= cmp_tag;
    if (wr_en)  data_mem[{idx, wr_word}]  <= wr_data;
  end

  if (WAYS > 1) begin : g_lru
    logic [AGE_W-1:0] age_mem [SETS];
    // Accessed way becomes youngest; every way younger than it ages by one,
    // so ages stay a permutation of 0..WAYS-1.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s < SETS; s++) age_mem[s] <= AGE_W'(WAY_ID);
      end else if (lru_upd) begin
        if (lru_sel)                         age_mem[idx] <= '0;
        else if (age_mem[idx] < lru_acc_age) age_mem[idx] <= age_mem[idx] + 1'b1;
      end
    end
    assign age = age_mem[idx];
  end else begin : g_no_lru
    assign age = '0;
  end
endmodule

module cache_nway_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int WORDS      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  miss_detected,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_wr_ack,
  input  logic                  stat_clr,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);
  localparam int WW    = $clog2(WORDS);
  localparam int OFF_W = WW + 1;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AGE_W = WAY_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t st, st_nxt;
  req_t   req_q;
  logic   replay;
  logic [WW-1:0]         cnt;
  logic [WAY_W-1:0]      vic_q, victim, hit_way;
  logic                  miss_det;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [WW-1:0]    req_word;

  logic [WAYS-1:0]                 hit_vec, vld_vec, wr_en, tag_wr, inv;
  logic [WAYS-1:0][AGE_W-1:0]      age_vec;
  logic [WAYS-1:0][DATA_WIDTH-1:0] rdata_vec;
  logic                  hit, fill_last, lru_upd, hit_inc, miss_inc;
  logic [AGE_W-1:0]      acc_age;
  logic [WW-1:0]         wr_word;
  logic [DATA_WIDTH-1:0] wr_data;

  assign req_tag   = req_q.addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx   = req_q.addr[OFF_W +: IDX_W];
  assign req_word  = req_q.addr[OFF_W-1:1];
  assign hit       = |hit_vec;
  assign fill_last = (cnt == WW'(WORDS - 1));
  assign lru_upd   = (st == LOOKUP) && hit;
  assign acc_age   = age_vec[hit_way];
  assign hit_inc   = (st == LOOKUP) && hit && !replay;
  assign miss_inc  = (st == LOOKUP) && !hit;
  assign wr_word   = (st == FILL) ? cnt : req_word;
  assign wr_data   = (st == FILL) ? mem_rd_data : req_q.wdata;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_nway_way #(
      .DATA_WIDTH(DATA_WIDTH), .SETS(SETS), .WORDS(WORDS), .TAG_W(TAG_W),
      .IDX_W(IDX_W), .WW(WW), .WAYS(WAYS), .AGE_W(AGE_W), .WAY_ID(w)
    ) u_way (
      .clk(clk), .rst(rst), .idx(req_idx), .word(req_word), .cmp_tag(req_tag),
      .hit(hit_vec[w]), .vld(vld_vec[w]), .age(age_vec[w]), .rdata(rdata_vec[w]),
      .wr_en(wr_en[w]), .wr_word(wr_word), .wr_data(wr_data), .tag_wr(tag_wr[w]),
      .inv(inv[w]), .lru_upd(lru_upd), .lru_acc_age(acc_age), .lru_sel(hit_vec[w])
    );
  end

  // Hit way encode and victim choice: lowest invalid way first, else the oldest.
  always_comb begin
    logic found;
    hit_way = '0;
    victim  = '0;
    found   = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (hit_vec[w]) hit_way = WAY_W'(w);
    for (int w = 0; w < WAYS; w++)
      if (!vld_vec[w] && !found) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    if (!found)
      for (int w = 0; w < WAYS; w++)
        if (age_vec[w] == AGE_W'(WAYS - 1)) victim = WAY_W'(w);
  end

  // Per-way write strobes: refill words go to the latched victim, write hits
  // go to the matching way.
  always_comb begin
    wr_en  = '0;
    tag_wr = '0;
    inv    = '0;
    for (int w = 0; w < WAYS; w++) begin
      wr_en[w]  = ((st == FILL) && mem_rd_valid && (vic_q == WAY_W'(w))) ||
                  ((st == LOOKUP) && req_q.we && hit_vec[w]);
      tag_wr[w] = (st == FILL) && mem_rd_valid && fill_last && (vic_q == WAY_W'(w));
      inv[w]    = (st == LOOKUP) && !hit && (victim == WAY_W'(w));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= st_nxt;
  end

  always_comb begin
    st_nxt      = st;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_rdata   = '0;
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    mem_wr_req  = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    unique case (st)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) st_nxt = LOOKUP;
      end
      LOOKUP: st_nxt = hit ? (req_q.we ? WRITE : RESP) : FILL;
      FILL: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = {req_tag, req_idx, cnt, 1'b0};
        if (mem_rd_valid && fill_last) st_nxt = LOOKUP;
      end
      WRITE: begin
        mem_wr_req  = 1'b1;
        mem_wr_addr = req_q.addr;
        mem_wr_data = req_q.wdata;
        if (mem_wr_ack) st_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        st_nxt    = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  assign miss_detected = miss_det;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q    <= '0;
      replay   <= 1'b0;
      cnt      <= '0;
      vic_q    <= '0;
      miss_det <= 1'b0;
      rdata_q  <= '0;
    end else begin
      unique case (st)
        IDLE: if (req_valid) begin
          req_q.we    <= req_we;
          req_q.addr  <= req_addr;
          req_q.wdata <= req_wdata;
          replay      <= 1'b0;
        end
        LOOKUP: if (hit) begin
          rdata_q <= req_q.we ? '0 : rdata_vec[hit_way];
        end else begin
          vic_q    <= victim;
          cnt      <= '0;
          miss_det <= 1'b1;
        end
        // After the last word the request replays through LOOKUP as a hit.
        FILL: if (mem_rd_valid) begin
          cnt <= cnt + 1'b1;
          if (fill_last) begin
            miss_det <= 1'b0;
            replay   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating counters; clear has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (stat_clr) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_inc  && (hit_count  != '1)) hit_count  <= hit_count  + 1'b1;
      if (miss_inc && (miss_count != '1)) miss_count <= miss_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_cache_nway_ctrl.sv
// Directed bench for cache_nway_ctrl: a 2-way default instance plus a 4-way
// instance for the LRU victim check. A bench-side memory answers each refill
// word 3 cycles apart and acks write-through after a chosen delay.
module tb_cache_nway_ctrl;
  logic clk, rst, sel;
  logic req_valid, req_we, mem_rd_valid, mem_wr_ack, stat_clr;
  logic [15:0] req_addr, req_wdata, mem_rd_data;

  logic d2_req_ready, d2_rsp_valid, d2_md, d2_rd_req, d2_wr_req;
  logic [15:0] d2_rdata, d2_rd_addr, d2_wr_addr, d2_wr_data, d2_hit, d2_miss;
  logic d4_req_ready, d4_rsp_valid, d4_md, d4_rd_req, d4_wr_req;
  logic [15:0] d4_rdata, d4_rd_addr, d4_wr_addr, d4_wr_data, d4_hit, d4_miss;

  logic o_req_ready, o_rsp_valid, o_md, o_rd_req, o_wr_req;
  logic [15:0] o_rdata, o_rd_addr, o_wr_addr, o_wr_data, o_hit, o_miss;

  int vectors = 0, miscompares = 0;

  cache_nway_ctrl u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(d2_req_ready),
    .rsp_valid(d2_rsp_valid), .rsp_rdata(d2_rdata), .miss_detected(d2_md),
    .mem_rd_req(d2_rd_req), .mem_rd_addr(d2_rd_addr),
    .mem_rd_valid(mem_rd_valid & ~sel), .mem_rd_data(mem_rd_data),
    .mem_wr_req(d2_wr_req), .mem_wr_addr(d2_wr_addr), .mem_wr_data(d2_wr_data),
    .mem_wr_ack(mem_wr_ack & ~sel), .stat_clr(stat_clr & ~sel),
    .hit_count(d2_hit), .miss_count(d2_miss));

  cache_nway_ctrl #(.WAYS(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(d4_req_ready),
    .rsp_valid(d4_rsp_valid), .rsp_rdata(d4_rdata), .miss_detected(d4_md),
    .mem_rd_req(d4_rd_req), .mem_rd_addr(d4_rd_addr),
    .mem_rd_valid(mem_rd_valid & sel), .mem_rd_data(mem_rd_data),
    .mem_wr_req(d4_wr_req), .mem_wr_addr(d4_wr_addr), .mem_wr_data(d4_wr_data),
    .mem_wr_ack(mem_wr_ack & sel), .stat_clr(stat_clr & sel),
    .hit_count(d4_hit), .miss_count(d4_miss));

  assign o_req_ready = sel ? d4_req_ready : d2_req_ready;
  assign o_rsp_valid = sel ? d4_rsp_valid : d2_rsp_valid;
  assign o_rdata     = sel ? d4_rdata     : d2_rdata;
  assign o_md        = sel ? d4_md        : d2_md;
  assign o_rd_req    = sel ? d4_rd_req    : d2_rd_req;
  assign o_rd_addr   = sel ? d4_rd_addr   : d2_rd_addr;
  assign o_wr_req    = sel ? d4_wr_req    : d2_wr_req;
  assign o_wr_addr   = sel ? d4_wr_addr   : d2_wr_addr;
  assign o_wr_data   = sel ? d4_wr_data   : d2_wr_data;
  assign o_hit       = sel ? d4_hit       : d2_hit;
  assign o_miss      = sel ? d4_miss      : d2_miss;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Main-memory contents: block 0x1230 holds 0xA000+k, everything else addr^0x5A5A.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a[15:4] == 12'h123) return 16'hA000 + {13'd0, a[3:1]};
    return a ^ 16'h5A5A;
  endfunction

  logic [15:0] r_data;
  int r_lat, r_nrd, r_wcyc, r_ack_cyc;
  logic r_md;
  logic [15:0] rd_addrs [16];

  // Issues one request at a negedge and serves memory until the response.
  // abort_words>0 returns right after that many refill words were consumed.
  task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                        input int ack_dly, input bit clr_lookup, input int abort_words);
    int cyc, fcnt;
    bit done;
    cyc = 0; fcnt = 0; done = 0;
    r_nrd = 0; r_wcyc = 0; r_md = 0; r_lat = -1; r_ack_cyc = -1; r_data = '0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    chk("req_ready_at_accept", {31'd0, o_req_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; cyc = 1;
    stat_clr = clr_lookup;
    while (!done && cyc < 400) begin
      if (abort_words != 0 && r_nrd == abort_words) begin
        mem_rd_valid = 1'b0;
        stat_clr = 1'b0;
        return;
      end
      if (o_rsp_valid) begin
        r_data = o_rdata; r_lat = cyc; done = 1;
      end else begin
        if (o_md) r_md = 1'b1;
        if (o_rd_req) begin
          fcnt++;
          if (fcnt == 3) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = mem_word(o_rd_addr);
            if (r_nrd < 16) rd_addrs[r_nrd] = o_rd_addr;
            r_nrd++;
            fcnt = 0;
          end else mem_rd_valid = 1'b0;
        end else begin
          mem_rd_valid = 1'b0; fcnt = 0;
        end
        if (o_wr_req) begin
          r_wcyc++;
          if (r_wcyc == 1) begin
            chk("wr_addr", {16'd0, o_wr_addr}, {16'd0, addr});
            chk("wr_data", {16'd0, o_wr_data}, {16'd0, wd});
          end
          if (r_wcyc > ack_dly) begin mem_wr_ack = 1'b1; r_ack_cyc = cyc; end
          else mem_wr_ack = 1'b0;
        end else mem_wr_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        cyc++;
        stat_clr = 1'b0;
      end
    end
    mem_rd_valid = 1'b0; mem_wr_ack = 1'b0; stat_clr = 1'b0;
    chk("rsp_seen", {31'd0, done}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("rsp_one_cycle", {31'd0, o_rsp_valid}, 32'd0);
    chk("back_to_idle", {31'd0, o_req_ready}, 32'd1);
  endtask

  task automatic rd(input logic [15:0] addr);
    access(1'b0, addr, 16'h0, 0, 1'b0, 0);
  endtask

  initial begin
    sel = 0; rst = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    mem_rd_valid = 0; mem_rd_data = 0; mem_wr_ack = 0; stat_clr = 0;
    repeat (2) @(negedge clk);
    // reset state
    chk("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {16'd0, o_rdata}, 32'd0);
    chk("rst_rd_req",    {31'd0, o_rd_req}, 32'd0);
    chk("rst_wr_req",    {31'd0, o_wr_req}, 32'd0);
    chk("rst_miss_det",  {31'd0, o_md}, 32'd0);
    chk("rst_hit_cnt",   {16'd0, o_hit}, 32'd0);
    chk("rst_miss_cnt",  {16'd0, o_miss}, 32'd0);
    rst = 1;
    @(negedge clk);

    // cold read miss with full block refill
    rd(16'h1234);
    chk("t1_rdata", {16'd0, r_data}, 32'h0000_A002);
    chk("t1_nwords", r_nrd, 32'd8);
    for (int k = 0; k < 8; k++)
      chk("t1_rd_addr", {16'd0, rd_addrs[k]}, 32'h1230 + 32'(2 * k));
    chk("t1_miss_det", {31'd0, r_md}, 32'd1);
    chk("t1_miss_cnt", {16'd0, o_miss}, 32'd1);
    chk("t1_hit_cnt",  {16'd0, o_hit}, 32'd0);

    // read hit: two-cycle latency, no refill
    rd(16'h1236);
    chk("t2_latency", r_lat, 32'd2);
    chk("t2_rdata", {16'd0, r_data}, 32'h0000_A003);
    chk("t2_nwords", r_nrd, 32'd0);
    chk("t2_hit_cnt", {16'd0, o_hit}, 32'd1);

    // write hit, write-through acked after 4 cycles
    access(1'b1, 16'h1236, 16'h5555, 4, 1'b0, 0);
    chk("t3_nwords", r_nrd, 32'd0);
    chk("t3_wr_held", r_wcyc, 32'd5);
    chk("t3_rsp_after_ack", r_lat - r_ack_cyc, 32'd1);
    chk("t3_hit_cnt", {16'd0, o_hit}, 32'd2);
    rd(16'h1236);
    chk("t3_readback", {16'd0, r_data}, 32'h0000_5555);
    chk("t3_hit_cnt2", {16'd0, o_hit}, 32'd3);

    // set 3, tags 0x04/0x08/0x04/0x0C: 0x08 is the LRU victim
    rd(16'h1030); chk("t4_a_nwords", r_nrd, 32'd8);
    chk("t4_a_rdata", {16'd0, r_data}, 32'h0000_4A6A);
    rd(16'h2030); chk("t4_b_nwords", r_nrd, 32'd8);
    rd(16'h1030); chk("t4_c_nwords", r_nrd, 32'd0);
    rd(16'h3030); chk("t4_d_nwords", r_nrd, 32'd8);
    chk("t4_d_rdata", {16'd0, r_data}, 32'h0000_6A6A);
    rd(16'h1030); chk("t4_e_nwords", r_nrd, 32'd0);
    rd(16'h2030); chk("t4_f_nwords", r_nrd, 32'd8);
    chk("t4_hit_cnt",  {16'd0, o_hit}, 32'd5);
    chk("t4_miss_cnt", {16'd0, o_miss}, 32'd5);

    // stat_clr coincident with a hit increment
    access(1'b0, 16'h1030, 16'h0, 0, 1'b1, 0);
    chk("t5_nwords", r_nrd, 32'd0);
    chk("t5_hit_cnt",  {16'd0, o_hit}, 32'd0);
    chk("t5_miss_cnt", {16'd0, o_miss}, 32'd0);
    rd(16'h1030);
    chk("t5_hit_cnt2", {16'd0, o_hit}, 32'd1);

    // reset in the middle of a refill
    access(1'b0, 16'h4000, 16'h0, 0, 1'b0, 3);
    chk("t6_pre_rd_req", {31'd0, o_rd_req}, 32'd1);
    rst = 0;
    #1;
    chk("t6_rd_req_drop", {31'd0, o_rd_req}, 32'd0);
    chk("t6_req_ready",   {31'd0, o_req_ready}, 32'd1);
    chk("t6_miss_det",    {31'd0, o_md}, 32'd0);
    chk("t6_hit_cnt",     {16'd0, o_hit}, 32'd0);
    chk("t6_miss_cnt",    {16'd0, o_miss}, 32'd0);
    @(negedge clk); rst = 1; @(negedge clk);
    rd(16'h4000);
    chk("t6_refetch_nwords", r_nrd, 32'd8);
    chk("t6_refetch_rdata", {16'd0, r_data}, 32'h0000_1A5A);
    chk("t6_miss_cnt2", {16'd0, o_miss}, 32'd1);

    // 4-way: fill set 5, touch way 0, miss evicts second-filled tag
    sel = 1; @(negedge clk);
    rd(16'h0050); rd(16'h0450); rd(16'h0850); rd(16'h0C50);
    rd(16'h0050); chk("t7_touch_nwords", r_nrd, 32'd0);
    rd(16'h1050); chk("t7_new_nwords", r_nrd, 32'd8);
    rd(16'h0050); chk("t7_tag0_kept", r_nrd, 32'd0);
    rd(16'h0850); chk("t7_tag2_kept", r_nrd, 32'd0);
    rd(16'h0C50); chk("t7_tag3_kept", r_nrd, 32'd0);
    chk("t7_tag3_rdata", {16'd0, r_data}, 32'h0000_560A);
    rd(16'h0450); chk("t7_tag1_evicted", r_nrd, 32'd8);
    chk("t7_hit_cnt",  {16'd0, o_hit}, 32'd4);
    chk("t7_miss_cnt", {16'd0, o_miss}, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cache_nway_ctrl.md
Name: cache_nway_ctrl

Overview:
- Parametrised N-way set-associative, write-through, write-allocate cache with an integrated miss-handling FSM, true-LRU replacement and hit/miss statistics counters.
- Next generation of the fixed 2-way tag/data cache: generalised in ways, sets, block size and data width.
- Owns the block refill sequence itself instead of relying on an external controller to drive write_tag_array.
- Sits between the pipeline memory stage (or fetch stage) and the multi-cycle main memory.

Parameters:
- ADDR_WIDTH, 16: byte address width.
- DATA_WIDTH, 16: word width; words are 2 bytes, so addr[0] is ignored.
- WAYS, 2: associativity; power of 2, range 1..8.
- SETS, 64: number of sets; power of 2.
- WORDS, 8: words per block; power of 2.
- CNT_WIDTH, 16: width of the statistics counters.
- Derived:
  - OFF_W = log2(WORDS) + 1
  - IDX_W = log2(SETS)
  - TAG_W = ADDR_WIDTH - IDX_W - OFF_W (6 at defaults)

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request present; held until accepted.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  write data.
- req_ready  out  1  cache can accept a request this cycle.
- rsp_valid  out  1  one-cycle pulse: read data valid, or write complete.
- rsp_rdata  out  DATA_WIDTH  read data; 0 when rsp_valid=0.
- miss_detected  out  1  high while a miss is being serviced.
- mem_rd_req  out  1  refill read request, level.
- mem_rd_addr  out  ADDR_WIDTH  word address being fetched.
- mem_rd_valid  in  1  refill word returned (in order).
- mem_rd_data  in  DATA_WIDTH  refill word.
- mem_wr_req  out  1  write-through request, level.
- mem_wr_addr  out  ADDR_WIDTH  write-through address.
- mem_wr_data  out  DATA_WIDTH  write-through data.
- mem_wr_ack  in  1  write-through accepted.
- stat_clr  in  1  synchronous clear of both counters.
- hit_count  out  CNT_WIDTH  saturating count of hit requests.
- miss_count  out  CNT_WIDTH  saturating count of miss requests.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All valid bits cleared.
  - LRU age of way w in every set set to w.
  - Counters set to 0.
  - All outputs 0 except req_ready=1.
  - Data and tag arrays are not reset.
  - Reset mid-refill or mid-write-through drops the request immediately. A partially filled line stays invalid.
- Address split: tag = addr[ADDR_WIDTH-1 -: TAG_W], index = next IDX_W bits, word = addr[OFF_W-1:1].
- FSM states: IDLE, LOOKUP, FILL, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/addr/wdata, clear replay flag, go to LOOKUP.
  - req_ready is 0 in every other state.
- LOOKUP:
  - Compare the latched tag against all valid ways of the set; at most one way may match.
  - Read hit:
    - Capture the word into rsp_rdata.
    - Update LRU.
    - Increment hit_count unless replay flag is set.
    - Go to RESP.
  - Write hit:
    - Write the word into the line.
    - Update LRU.
    - Count as for a read hit.
    - Go to WRITE.
  - Miss:
    - Increment miss_count.
    - Choose the victim: the lowest-index invalid way; otherwise the way with age WAYS-1.
    - Clear the victim's valid bit, reset word counter, set miss_detected, go to FILL.
- FILL:
  - mem_rd_req=1, mem_rd_addr = block base + 2*counter.
  - Each cycle with mem_rd_valid: write mem_rd_data into victim word[counter], counter++.
  - mem_rd_valid in any other state is ignored.
  - On the WORDS-th word: write tag, set valid, clear miss_detected, set replay flag, go to LOOKUP. The replay is then a guaranteed hit; it is not counted as a hit.
- WRITE:
  - mem_wr_req=1 with the latched addr/data, held until mem_wr_ack.
  - On ack go to RESP.
  - mem_wr_ack outside WRITE is ignored.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - Read hit latency: accept edge to rsp_valid is 2 cycles. Maximum throughput is one request per 3 cycles.
- LRU update on access to way a with age A:
  - Every way in the set with age < A increments.
  - Way a is set to 0.
  - Ages remain a permutation of 0..WAYS-1.
  - WAYS=1: LRU logic is absent; the victim is always way 0.
- Counters:
  - Saturate at all-ones.
  - stat_clr wins over a coincident increment.
- miss_detected: registered; high from the edge leaving LOOKUP-on-miss through the last refill word.

Test Plan:
- Reset, then read 0x1234 with memory returning word k = 0xA000+k after 3 cycles each -> miss_detected high, 8 mem_rd addresses 0x1230..0x123E, rsp_rdata=0xA002, miss_count=1, hit_count=0.
- Re-read 0x1236 -> rsp_valid exactly 2 cycles after accept, data 0xA003, no mem_rd_req, hit_count=1.
- Write 0x5555 to 0x1236 (hit) -> mem_wr_req held with addr 0x1236/data 0x5555 until ack delayed 4 cycles; rsp_valid one cycle after ack; subsequent read returns 0x5555.
- Defaults: access tags 0x04, 0x08, 0x04, 0x0C in set 3 -> third access hits; fourth evicts tag 0x08's way; re-reading tag 0x04 hits.
- WAYS=4: fill 4 tags in one set, touch way 0, then miss -> victim is the way filled second (oldest).
- Assert rst low mid-FILL after 3 words -> mem_rd_req drops same cycle, req_ready=1, counters 0, next access to that block misses; stat_clr with coincident hit -> count 0.
